// File: rtl/alu_vector_checker.sv
// ALU self-check engine: replays stored vectors from a 1-cycle-latency vector memory
// into the ALU, compares the ALU result and flags against the stored expectations and
// keeps saturating vector/error counters plus the index of the first failing vector.
// Each vector takes three cycles: FETCH (memory read), LOAD (capture), CHECK (compare).
module alu_vector_checker #(
    parameter int LOGWIDTH = 5,
    parameter int ADDRW    = 14,
    parameter int CNTW     = 32,
    localparam int W       = 2 ** LOGWIDTH,
    localparam int VW      = 3 * W + 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ADDRW-1:0] num_vec,
    output logic [ADDRW-1:0] vec_addr,
    output logic             vec_rd,
    input  logic [VW-1:0]    vec_data,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_f,
    input  logic [W-1:0]     alu_y,
    input  logic             alu_cout,
    input  logic             alu_oflow,
    input  logic             alu_zero,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  vec_count,
    output logic [CNTW-1:0]  err_count,
    output logic [ADDRW-1:0] first_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [ADDRW-1:0] r_num_vec;
    logic [ADDRW-1:0] r_idx;
    logic [ADDRW-1:0] r_vec_addr;
    logic [ADDRW-1:0] r_first_fail;
    logic             r_vec_rd;
    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_alu_a;
    logic [W-1:0]     r_alu_b;
    logic [2:0]       r_alu_f;
    logic [W-1:0]     r_yexp;
    logic [2:0]       r_fexp;
    logic [CNTW-1:0]  r_vec_count;
    logic [CNTW-1:0]  r_err_count;

    // Vector word fields, MSB first: {A, B, F, Yexp, Cexp, Oexp, Zexp}
    logic [W-1:0] w_vec_a;
    logic [W-1:0] w_vec_b;
    logic [2:0]   w_vec_f;
    logic [W-1:0] w_vec_y;
    logic [2:0]   w_vec_flags;

    assign w_vec_a     = vec_data[3*W+5 -: W];
    assign w_vec_b     = vec_data[2*W+5 -: W];
    assign w_vec_f     = vec_data[W+5 -: 3];
    assign w_vec_y     = vec_data[W+2 -: W];
    assign w_vec_flags = vec_data[2:0];

    // Result and flag groups are scored separately, so one vector can add up to 2 errors.
    logic             w_y_bad;
    logic             w_flag_bad;
    logic [1:0]       w_err_inc;
    logic [CNTW:0]    w_err_sum;
    logic [CNTW-1:0]  w_err_next;
    logic [CNTW-1:0]  w_vec_next;
    logic             w_last;

    assign w_y_bad    = (alu_y != r_yexp);
    assign w_flag_bad = ({alu_cout, alu_oflow, alu_zero} != r_fexp);
    assign w_err_inc  = {1'b0, w_y_bad} + {1'b0, w_flag_bad};
    assign w_err_sum  = {1'b0, r_err_count} + {{(CNTW-1){1'b0}}, w_err_inc};
    // Carry out of the widened sum means the counter would wrap: pin it at all-ones.
    assign w_err_next = w_err_sum[CNTW] ? {CNTW{1'b1}} : w_err_sum[CNTW-1:0];
    assign w_vec_next = (&r_vec_count) ? r_vec_count
                                       : r_vec_count + {{(CNTW-1){1'b0}}, 1'b1};
    assign w_last     = (r_idx == r_num_vec - {{(ADDRW-1){1'b0}}, 1'b1});

    assign vec_addr   = r_vec_addr;
    assign vec_rd     = r_vec_rd;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_f      = r_alu_f;
    assign busy       = r_busy;
    assign done       = r_done;
    assign vec_count  = r_vec_count;
    assign err_count  = r_err_count;
    assign first_fail = r_first_fail;

    // Run-control FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_num_vec    <= '0;
            r_idx        <= '0;
            r_vec_addr   <= '0;
            r_first_fail <= '0;
            r_vec_rd     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_f      <= '0;
            r_yexp       <= '0;
            r_fexp       <= '0;
            r_vec_count  <= '0;
            r_err_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_num_vec    <= num_vec;
                        r_idx        <= '0;
                        r_vec_count  <= '0;
                        r_err_count  <= '0;
                        r_first_fail <= '0;
                        if (num_vec == '0) begin
                            // Empty run: report completion at once, no memory traffic.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_FETCH;
                            r_done     <= 1'b0;
                            r_busy     <= 1'b1;
                            r_vec_rd   <= 1'b1;
                            r_vec_addr <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    r_vec_rd <= 1'b0;
                    r_state  <= S_LOAD;
                end
                S_LOAD: begin
                    // ALU operands change only here, so they are stable for all of CHECK.
                    r_alu_a <= w_vec_a;
                    r_alu_b <= w_vec_b;
                    r_alu_f <= w_vec_f;
                    r_yexp  <= w_vec_y;
                    r_fexp  <= w_vec_flags;
                    r_state <= S_LOAD == S_LOAD ? S_CHECK : S_CHECK;
                end
                S_CHECK: begin
                    r_vec_count <= w_vec_next;
                    r_err_count <= w_err_next;
                    // A saturated error count never returns to zero, so this marks the first failure only.
                    if ((w_y_bad || w_flag_bad) && (r_err_count == '0)) begin
                        r_first_fail <= r_idx;
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx      <= r_idx + {{(ADDRW-1){1'b0}}, 1'b1};
                        r_vec_addr <= r_idx + {{(ADDRW-1){1'b0}}, 1'b1};
                        r_vec_rd   <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
